// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the frequency-meter measurement path.
package freq_meter_pkg;

   typedef enum logic [2:0] {IDLE, CLEAR, GATE, SETTLE, LATCH} state_t;

   localparam logic [1:0] RANGE_1S    = 2'd0;
   localparam logic [1:0] RANGE_100MS = 2'd1;
   localparam logic [1:0] RANGE_10MS  = 2'd2;
   localparam logic [1:0] RANGE_1MS   = 2'd3;

   localparam int BCD_DIGITS = 6;
   localparam int CNT_W      = 4 * BCD_DIGITS;

   // Gate length in clock cycles for a range; never returns 0.
   function automatic logic [31:0] gate_len(input int unsigned clk_hz, input logic [1:0] rng);
      int unsigned len;
      case (rng)
         RANGE_1S:    len = clk_hz;
         RANGE_100MS: len = clk_hz / 10;
         RANGE_10MS:  len = clk_hz / 100;
         default:     len = clk_hz / 1000;
      endcase
      if (len == 0) len = 1;
      return len;
   endfunction

endpackage

// File: rtl/freq_gate_ctrl_gate_timer.sv
// Loadable 32-bit down-counter with zero flag; holds at zero.
module gate_timer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] load_val,
   output logic        zero
);

   logic [31:0] cnt;

   // Load takes priority; otherwise count down until zero is reached.
   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != 32'd0)
         cnt <= cnt - 32'd1;
   end

   assign zero = (cnt == 32'd0);

endmodule

// File: rtl/freq_gate_ctrl.sv
// Measurement sequencer for the BCD event counter: clear, timed gate,
// settle, latch. Optional build macro FREQ_GATE_AUTO_RANGE_EN selects
// automatic range stepping when re-arming from LATCH.
module freq_gate_ctrl
   import freq_meter_pkg::*;
#(
   parameter int unsigned CLK_HZ        = 50000000,
   parameter int unsigned CLR_CYCLES    = 4,
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic             CONT,
   input  logic [1:0]       RANGE,
   input  logic [CNT_W-1:0] CNT_Q,
   output logic             CNT_ENA,
   output logic             CNT_CLR,
   output logic [CNT_W-1:0] RESULT,
   output logic [1:0]       RANGE_USED,
   output logic             VALID,
   output logic             BUSY
);

   localparam logic [31:0] CLR_LOAD    = 32'(CLR_CYCLES - 1);
   localparam logic [31:0] SETTLE_LOAD = 32'(SETTLE_CYCLES - 1);
   localparam logic [31:0] GATE_LEN_0  = gate_len(CLK_HZ, RANGE_1S);
   localparam logic [31:0] GATE_LEN_1  = gate_len(CLK_HZ, RANGE_100MS);
   localparam logic [31:0] GATE_LEN_2  = gate_len(CLK_HZ, RANGE_10MS);
   localparam logic [31:0] GATE_LEN_3  = gate_len(CLK_HZ, RANGE_1MS);

   state_t           state, state_nxt;
   logic [1:0]       range_r, range_nxt, rearm_range;
   logic [31:0]      gate_sel, tmr_val;
   logic             tmr_load, tmr_zero;
   logic             cnt_ena_p1, cnt_clr_p1, busy_p1, vld_p1;
   logic [CNT_W-1:0] result_p1;
   logic [1:0]       range_used_p1;

   gate_timer u_timer (
      .clk      (CLK),
      .rst_n    (RST_N),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   // Gate length for the range latched at arm time.
   always_comb begin
      case (range_r)
         RANGE_1S:    gate_sel = GATE_LEN_0;
         RANGE_100MS: gate_sel = GATE_LEN_1;
         RANGE_10MS:  gate_sel = GATE_LEN_2;
         default:     gate_sel = GATE_LEN_3;
      endcase
   end

`ifdef FREQ_GATE_AUTO_RANGE_EN
   // Step toward a shorter gate near full scale, longer with two leading zero digits.
   always_comb begin
      rearm_range = range_r;
      if (CNT_Q[23:20] != 4'd0 && range_r < RANGE_1MS)
         rearm_range = range_r + 2'd1;
      else if (CNT_Q[23:16] == 8'd0 && range_r > RANGE_1S)
         rearm_range = range_r - 2'd1;
   end
`else
   assign rearm_range = RANGE;
`endif

   // Next-state, timer reload and range selection.
   always_comb begin
      state_nxt = state;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      range_nxt = range_r;
      case (state)
         IDLE: begin
            if (START || CONT) begin
               state_nxt = CLEAR;
               tmr_load  = 1'b1;
               tmr_val   = CLR_LOAD;
               range_nxt = RANGE;
            end
         end
         CLEAR: begin
            if (tmr_zero) begin
               state_nxt = GATE;
               tmr_load  = 1'b1;
               tmr_val   = gate_sel - 32'd1;
            end
         end
         GATE: begin
            if (tmr_zero) begin
               state_nxt = SETTLE;
               tmr_load  = 1'b1;
               tmr_val   = SETTLE_LOAD;
            end
         end
         SETTLE: begin
            if (tmr_zero) state_nxt = LATCH;
         end
         LATCH: begin
            if (START || CONT) begin
               state_nxt = CLEAR;
               tmr_load  = 1'b1;
               tmr_val   = CLR_LOAD;
               range_nxt = rearm_range;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and registered outputs; result is captured on entry to LATCH so
   // VALID and the new RESULT appear in the same cycle.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state         <= IDLE;
         range_r       <= RANGE_1S;
         cnt_ena_p1    <= 1'b0;
         cnt_clr_p1    <= 1'b0;
         busy_p1       <= 1'b0;
         vld_p1        <= 1'b0;
         result_p1     <= '0;
         range_used_p1 <= RANGE_1S;
      end else begin
         state      <= state_nxt;
         range_r    <= range_nxt;
         cnt_ena_p1 <= (state_nxt == GATE);
         cnt_clr_p1 <= (state_nxt == CLEAR);
         busy_p1    <= (state_nxt != IDLE);
         vld_p1     <= (state_nxt == LATCH);
         if (state_nxt == LATCH) begin
            result_p1     <= CNT_Q;
            range_used_p1 <= range_r;
         end
      end
   end

   assign CNT_ENA    = cnt_ena_p1;
   assign CNT_CLR    = cnt_clr_p1;
   assign BUSY       = busy_p1;
   assign VALID      = vld_p1;
   assign RESULT     = result_p1;
   assign RANGE_USED = range_used_p1;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Directed bench for freq_gate_ctrl with CLK_HZ=1000 (gates 1000/100/10/1).
module tb_freq_gate_ctrl;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        START = 1'b0;
   logic        CONT = 1'b0;
   logic [1:0]  RANGE = 2'd0;
   logic [23:0] CNT_Q = 24'h0;
   logic        CNT_ENA, CNT_CLR, VALID, BUSY;
   logic [23:0] RESULT;
   logic [1:0]  RANGE_USED;

   int vectors = 0;
   int miscompares = 0;

   freq_gate_ctrl #(.CLK_HZ(1000), .CLR_CYCLES(4), .SETTLE_CYCLES(4)) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .START      (START),
      .CONT       (CONT),
      .RANGE      (RANGE),
      .CNT_Q      (CNT_Q),
      .CNT_ENA    (CNT_ENA),
      .CNT_CLR    (CNT_CLR),
      .RESULT     (RESULT),
      .RANGE_USED (RANGE_USED),
      .VALID      (VALID),
      .BUSY       (BUSY)
   );

   always #5 CLK = ~CLK;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got running, want finished");
      $fatal(1);
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic apply_reset();
      RST_N = 1'b0;
      START = 1'b0;
      CONT  = 1'b0;
      tick();
      tick();
      RST_N = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      logic [30:0] outs;
      RST_N = 1'b0;
      for (int i = 0; i < 3; i++) begin
         START = ~START;
         CONT  = ~CONT;
         RANGE = RANGE + 2'd1;
         CNT_Q = CNT_Q + 24'h111111;
         tick();
         outs = {CNT_ENA, CNT_CLR, VALID, BUSY, RESULT, RANGE_USED};
         vectors++;
         if (outs !== 31'd0) begin
            miscompares++;
            $display("FAIL reset_outputs cycle %0d: got %h want 0", i, outs);
         end
      end
      START = 1'b0;
      CONT  = 1'b0;
      RANGE = 2'd2;
      RST_N = 1'b1;
      tick();
      START = 1'b1;
      tick();
      START = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #2 RST_N = 1'b0;
         #2 RST_N = 1'b1;
         tick();
         vectors++;
         if ({CNT_CLR, BUSY} !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_glitch %0d: got clr/busy=%b want 11", i, {CNT_CLR, BUSY});
         end
      end
      apply_reset();
   endtask

   task automatic test_single();
      logic exp_clr, exp_ena, exp_vld, exp_busy;
      RANGE = 2'd2;
      CNT_Q = 24'h000123;
      START = 1'b1;
      tick();
      START = 1'b0;
      for (int i = 1; i <= 22; i++) begin
         exp_clr  = (i >= 1 && i <= 4);
         exp_ena  = (i >= 5 && i <= 14);
         exp_vld  = (i == 19);
         exp_busy = (i <= 19);
         vectors++;
         if ({CNT_CLR, CNT_ENA, VALID, BUSY} !== {exp_clr, exp_ena, exp_vld, exp_busy}) begin
            miscompares++;
            $display("FAIL single_ctl cycle %0d: got clr/ena/vld/busy=%b want %b", i,
                     {CNT_CLR, CNT_ENA, VALID, BUSY}, {exp_clr, exp_ena, exp_vld, exp_busy});
         end
         if (i == 19) begin
            vectors++;
            if (RESULT !== 24'h000123 || RANGE_USED !== 2'd2) begin
               miscompares++;
               $display("FAIL single_result: got %h/%0d want 000123/2", RESULT, RANGE_USED);
            end
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      int p;
      logic exp_clr, exp_ena, exp_vld;
      RANGE = 2'd3;
      CNT_Q = 24'h900000;
      CONT  = 1'b1;
      tick();
      for (int i = 1; i <= 30; i++) begin
         p = (i - 1) % 10;
         exp_clr = (p < 4);
         exp_ena = (p == 4);
         exp_vld = (p == 9);
         vectors++;
         if ({CNT_CLR, CNT_ENA, VALID, BUSY} !== {exp_clr, exp_ena, exp_vld, 1'b1}) begin
            miscompares++;
            $display("FAIL cont_ctl cycle %0d: got clr/ena/vld/busy=%b want %b", i,
                     {CNT_CLR, CNT_ENA, VALID, BUSY}, {exp_clr, exp_ena, exp_vld, 1'b1});
         end
         if (p == 9) begin
            vectors++;
            if (RESULT !== 24'h900000 || RANGE_USED !== 2'd3) begin
               miscompares++;
               $display("FAIL cont_result cycle %0d: got %h/%0d want 900000/3", i, RESULT, RANGE_USED);
            end
         end
         tick();
      end
      CONT = 1'b0;
      for (int n = 0; n < 40 && BUSY; n++) tick();
      vectors++;
      if (BUSY !== 1'b0) begin
         miscompares++;
         $display("FAIL cont_drain: got busy=%b want 0 within 40 cycles", BUSY);
      end
   endtask

   task automatic test_abort();
      logic seen_activity;
      apply_reset();
      RANGE = 2'd2;
      CNT_Q = 24'h000777;
      START = 1'b1;
      tick();
      START = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      vectors++;
      if (CNT_ENA !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_in_gate: got ena=%b want 1", CNT_ENA);
      end
      RST_N = 1'b0;
      tick();
      vectors++;
      if ({CNT_ENA, CNT_CLR, VALID, BUSY} !== 4'b0000 || RESULT !== 24'h0) begin
         miscompares++;
         $display("FAIL abort_outputs: got ctl=%b result=%h want 0000/000000",
                  {CNT_ENA, CNT_CLR, VALID, BUSY}, RESULT);
      end
      RST_N = 1'b1;
      seen_activity = 1'b0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (VALID || BUSY) seen_activity = 1'b1;
      end
      vectors++;
      if (seen_activity !== 1'b0 || RESULT !== 24'h0) begin
         miscompares++;
         $display("FAIL abort_quiet: got activity=%b result=%h want 0/000000", seen_activity, RESULT);
      end
   endtask

   task automatic test_range_change();
      int ena_cnt;
      CNT_Q = 24'h000001;
      RANGE = 2'd0;
      CONT  = 1'b1;
      tick();
      ena_cnt = 0;
      for (int i = 1; i <= 1020; i++) begin
         if (i == 10) RANGE = 2'd3;
         if (i <= 1008 && CNT_ENA) ena_cnt++;
         if (i == 1009) begin
            vectors++;
            if (VALID !== 1'b1 || RANGE_USED !== 2'd0) begin
               miscompares++;
               $display("FAIL rchg_valid: got vld/range=%b/%0d want 1/0", VALID, RANGE_USED);
            end
         end
`ifndef FREQ_GATE_AUTO_RANGE_EN
         if (i == 1014 || i == 1015) begin
            vectors++;
            if (CNT_ENA !== (i == 1014)) begin
               miscompares++;
               $display("FAIL rchg_second_gate cycle %0d: got ena=%b want %b", i, CNT_ENA, (i == 1014));
            end
         end
`endif
         tick();
      end
      vectors++;
      if (ena_cnt !== 1000) begin
         miscompares++;
         $display("FAIL rchg_first_gate: got %0d cycles want 1000", ena_cnt);
      end
      CONT = 1'b0;
      for (int n = 0; n < 1200 && BUSY; n++) tick();
      vectors++;
      if (BUSY !== 1'b0) begin
         miscompares++;
         $display("FAIL rchg_drain: got busy=%b want 0 within 1200 cycles", BUSY);
      end
   endtask

`ifdef FREQ_GATE_AUTO_RANGE_EN
   task automatic test_auto_range();
      int runs [3];
      int nruns;
      int cur;
      runs  = '{0, 0, 0};
      nruns = 0;
      cur   = 0;
      CNT_Q = 24'h100000;
      RANGE = 2'd1;
      CONT  = 1'b1;
      tick();
      for (int i = 1; i <= 240; i++) begin
         if (i == 115) CNT_Q = 24'h000050;
         if (CNT_ENA) cur++;
         else if (cur > 0) begin
            if (nruns < 3) runs[nruns] = cur;
            nruns++;
            cur = 0;
         end
         if (i == 109 || i == 128) begin
            vectors++;
            if (VALID !== 1'b1 || RANGE_USED !== ((i == 109) ? 2'd1 : 2'd2)) begin
               miscompares++;
               $display("FAIL auto_valid cycle %0d: got vld/range=%b/%0d want 1/%0d", i, VALID,
                        RANGE_USED, (i == 109) ? 1 : 2);
            end
         end
         tick();
      end
      vectors++;
      if (runs[0] !== 100 || runs[1] !== 10 || runs[2] !== 100) begin
         miscompares++;
         $display("FAIL auto_gates: got %0d/%0d/%0d want 100/10/100", runs[0], runs[1], runs[2]);
      end
      CONT = 1'b0;
      for (int n = 0; n < 400 && BUSY; n++) tick();
      vectors++;
      if (BUSY !== 1'b0) begin
         miscompares++;
         $display("FAIL auto_drain: got busy=%b want 0 within 400 cycles", BUSY);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_abort();
      test_range_change();
`ifdef FREQ_GATE_AUTO_RANGE_EN
      test_auto_range();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
